// File: rtl/cam_lvds_aligner.sv
// Per-camera LVDS word aligner: bitslips each of the 5 lanes until the
// lane word equals the training word, then reports per-lane lock status.
//
// Ports:
//   c            - camera rx_coreclock
//   rst_n        - asynchronous active-low reset
//   rxd[39:0]    - deserialized lane words, lane i at [8i+7:8i], lane 4 = sync
//   rx_locked    - deserializer PLL lock, asynchronous to c
//   restart      - synchronous pulse, restarts alignment on all lanes
//   bitslip[4:0] - one-cycle bitslip pulse per lane
//   lane_aligned - per-lane aligned flag
//   lane_fail    - per-lane failure flag
//   all_aligned  - AND of lane_aligned
//   slip_cnt     - slips performed, 4 bits per lane
module cam_lvds_aligner #(
    parameter logic [7:0]  TRAINING    = 8'h3A,
    parameter int unsigned MATCH_COUNT = 16,
    parameter int unsigned SLIP_WAIT   = 8,
    parameter int unsigned MAX_SLIPS   = 15,
    parameter int unsigned LOCK_WAIT   = 64
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic [39:0] rxd,
    input  logic        rx_locked,
    input  logic        restart,
    output logic [4:0]  bitslip,
    output logic [4:0]  lane_aligned,
    output logic [4:0]  lane_fail,
    output logic        all_aligned,
    output logic [19:0] slip_cnt
);

    localparam logic [7:0] MC = 8'(MATCH_COUNT);
    localparam logic [7:0] SW = 8'(SLIP_WAIT);
    localparam logic [3:0] MS = 4'(MAX_SLIPS);
    localparam logic [7:0] LW = 8'(LOCK_WAIT);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_ALIGNED,
        ST_FAILED
    } lane_state_e;

    logic        sync1_q;
    logic        lock_s_q;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        lock_ok;
    logic [39:0] rxd_q;

    lane_state_e state_q [5];
    lane_state_e state_d [5];
    logic [7:0]  match_q [5];
    logic [7:0]  match_d [5];
    logic [3:0]  slip_q  [5];
    logic [3:0]  slip_d  [5];
    logic [7:0]  wait_q  [5];
    logic [7:0]  wait_d  [5];

    logic [4:0]  bitslip_q, bitslip_d;
    logic [4:0]  aligned_q, aligned_d;
    logic [4:0]  fail_q, fail_d;

    assign lock_ok = (lock_cnt_q == LW);

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!lock_s_q) begin
            lock_cnt_d = '0;
        end else if (!lock_ok) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
    end

    always_comb begin
        bitslip_d = '0;
        aligned_d = '0;
        fail_d    = '0;
        for (int i = 0; i < 5; i++) begin
            state_d[i] = state_q[i];
            match_d[i] = match_q[i];
            slip_d[i]  = slip_q[i];
            wait_d[i]  = wait_q[i];
            if (restart || !lock_s_q) begin
                state_d[i] = ST_WAIT_LOCK;
                match_d[i] = '0;
                slip_d[i]  = '0;
                wait_d[i]  = '0;
            end else begin
                unique case (state_q[i])
                    ST_WAIT_LOCK: begin
                        match_d[i] = '0;
                        slip_d[i]  = '0;
                        wait_d[i]  = '0;
                        if (lock_ok) state_d[i] = ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (rxd_q[8*i +: 8] == TRAINING) begin
                            match_d[i] = match_q[i] + 8'd1;
                            if (match_d[i] == MC) state_d[i] = ST_ALIGNED;
                        end else begin
                            match_d[i] = '0;
                            state_d[i] = (slip_q[i] == MS) ? ST_FAILED
                                                           : ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        // Pulse leaves the flop on the edge that exits SLIP,
                        // so a restart in this cycle still suppresses it.
                        bitslip_d[i] = 1'b1;
                        slip_d[i]    = slip_q[i] + 4'd1;
                        wait_d[i]    = '0;
                        state_d[i]   = ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (wait_q[i] == SW) begin
                            wait_d[i]  = '0;
                            state_d[i] = ST_CHECK;
                        end else begin
                            wait_d[i] = wait_q[i] + 8'd1;
                        end
                    end
                    ST_ALIGNED: state_d[i] = ST_ALIGNED;
                    ST_FAILED:  state_d[i] = ST_FAILED;
                    default:    state_d[i] = ST_WAIT_LOCK;
                endcase
            end
            aligned_d[i] = (state_d[i] == ST_ALIGNED);
            fail_d[i]    = (state_d[i] == ST_FAILED);
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            lock_s_q   <= 1'b0;
            lock_cnt_q <= '0;
            rxd_q      <= '0;
            bitslip_q  <= '0;
            aligned_q  <= '0;
            fail_q     <= '0;
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= ST_WAIT_LOCK;
                match_q[i] <= '0;
                slip_q[i]  <= '0;
                wait_q[i]  <= '0;
            end
        end else begin
            sync1_q    <= rx_locked;
            lock_s_q   <= sync1_q;
            lock_cnt_q <= lock_cnt_d;
            rxd_q      <= rxd;
            bitslip_q  <= bitslip_d;
            aligned_q  <= aligned_d;
            fail_q     <= fail_d;
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                match_q[i] <= match_d[i];
                slip_q[i]  <= slip_d[i];
                wait_q[i]  <= wait_d[i];
            end
        end
    end

    assign bitslip      = bitslip_q;
    assign lane_aligned = aligned_q;
    assign lane_fail    = fail_q;
    assign all_aligned  = &aligned_q;
    assign slip_cnt     = {slip_q[4], slip_q[3], slip_q[2],
                           slip_q[1], slip_q[0]};

endmodule

// File: tb/tb_cam_lvds_aligner.sv
// Bench for cam_lvds_aligner: lane model rotates a word per bitslip pulse,
// expected pulses are queued and matched against observed ones.
module tb_cam_lvds_aligner;

    localparam logic [7:0] TRN = 8'h3A;

    typedef struct {
        int lane;
        int cyc;
    } pulse_t;

    logic        c = 1'b0;
    logic        rst_n;
    logic [39:0] rxd;
    logic        rx_locked;
    logic        restart;
    logic [4:0]  bitslip;
    logic [4:0]  lane_aligned;
    logic [4:0]  lane_fail;
    logic        all_aligned;
    logic [19:0] slip_cnt;

    logic [7:0] lw [5];
    pulse_t     exp_q [$];
    pulse_t     obs_q [$];
    int         cyc;
    int         t0;
    int         n_cmp;
    int         n_bad;

    assign rxd = {lw[4], lw[3], lw[2], lw[1], lw[0]};

    always #5 c = ~c;

    cam_lvds_aligner dut (
        .c            (c),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .rx_locked    (rx_locked),
        .restart      (restart),
        .bitslip      (bitslip),
        .lane_aligned (lane_aligned),
        .lane_fail    (lane_fail),
        .all_aligned  (all_aligned),
        .slip_cnt     (slip_cnt)
    );

    function automatic logic [7:0] rotr(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int k = 0; k < n; k++) r = {r[0], r[7:1]};
        return r;
    endfunction

    // One clock: count the edge, then at the falling edge record pulses
    // and let the deserializer model rotate the slipped lanes.
    task automatic tick();
        @(posedge c);
        cyc++;
        @(negedge c);
        for (int i = 0; i < 5; i++) begin
            if (bitslip[i]) begin
                obs_q.push_back('{lane: i, cyc: cyc});
                lw[i] = {lw[i][6:0], lw[i][7]};
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic relock();
        rx_locked = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++;
        if ({bitslip, lane_aligned, lane_fail, all_aligned} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_flags: got %h want 0",
                     {bitslip, lane_aligned, lane_fail, all_aligned});
        end
        n_cmp++;
        if (slip_cnt !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_slip_cnt: got %h want 0", slip_cnt);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_already_aligned();
        rx_locked = 1'b1;
        t0 = cyc;
        run_to(t0 + 82);
        n_cmp++;
        if (lane_aligned !== 5'h00) begin
            n_bad++;
            $display("FAIL aligned_early: got %b want 00000", lane_aligned);
        end
        tick();
        n_cmp++;
        if (lane_aligned !== 5'h1f || all_aligned !== 1'b1) begin
            n_bad++;
            $display("FAIL aligned_time: got %b/%b want 11111/1",
                     lane_aligned, all_aligned);
        end
        n_cmp++;
        if (slip_cnt !== 20'h0) begin
            n_bad++;
            $display("FAIL aligned_slips: got %h want 0", slip_cnt);
        end
        n_cmp++;
        if (obs_q.size() !== 0) begin
            n_bad++;
            $display("FAIL aligned_pulses: got %0d want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_lock_loss();
        rx_locked = 1'b0;
        t0 = cyc;
        repeat (4) tick();
        n_cmp++;
        if (lane_aligned !== 5'h00 || all_aligned !== 1'b0) begin
            n_bad++;
            $display("FAIL lockloss_clear: got %b/%b want 00000/0",
                     lane_aligned, all_aligned);
        end
        n_cmp++;
        if (slip_cnt !== 20'h0) begin
            n_bad++;
            $display("FAIL lockloss_slips: got %h want 0", slip_cnt);
        end
        rx_locked = 1'b1;
        t0 = cyc;
        run_to(t0 + 82);
        n_cmp++;
        if (all_aligned !== 1'b0) begin
            n_bad++;
            $display("FAIL relock_early: got %b want 0", all_aligned);
        end
        tick();
        n_cmp++;
        if (all_aligned !== 1'b1) begin
            n_bad++;
            $display("FAIL relock_time: got %b want 1", all_aligned);
        end
    endtask

    task automatic test_three_slips();
        pulse_t e, o;
        relock();
        lw[2] = rotr(TRN, 3);
        rx_locked = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back('{lane: 2, cyc: t0 + 69 + 11*k});
        run_to(t0 + 115);
        n_cmp++;
        if (lane_aligned !== 5'h1b) begin
            n_bad++;
            $display("FAIL slip3_early: got %b want 11011", lane_aligned);
        end
        tick();
        n_cmp++;
        if (lane_aligned !== 5'h1f || slip_cnt !== 20'h00300) begin
            n_bad++;
            $display("FAIL slip3_done: got %b/%h want 11111/00300",
                     lane_aligned, slip_cnt);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL slip3_count: got %0d extra, want %0d more",
                         obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.lane !== e.lane || o.cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL slip3_pulse: got lane %0d cyc %0d want lane %0d cyc %0d",
                             o.lane, o.cyc - t0, e.lane, e.cyc - t0);
                end
            end
        end
    endtask

    task automatic test_unalignable();
        pulse_t e, o;
        relock();
        lw[4] = 8'h00;
        rx_locked = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 15; k++) exp_q.push_back('{lane: 4, cyc: t0 + 69 + 11*k});
        run_to(t0 + 232);
        n_cmp++;
        if (lane_fail !== 5'h00) begin
            n_bad++;
            $display("FAIL fail_early: got %b want 00000", lane_fail);
        end
        tick();
        n_cmp++;
        if (lane_fail !== 5'h10 || lane_aligned !== 5'h0f) begin
            n_bad++;
            $display("FAIL fail_flags: got %b/%b want 10000/01111",
                     lane_fail, lane_aligned);
        end
        repeat (30) tick();
        n_cmp++;
        if (all_aligned !== 1'b0 || slip_cnt !== 20'hf0000) begin
            n_bad++;
            $display("FAIL fail_hold: got %b/%h want 0/f0000",
                     all_aligned, slip_cnt);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL fail_count: got %0d extra, want %0d more",
                         obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.lane !== e.lane || o.cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL fail_pulse: got lane %0d cyc %0d want lane %0d cyc %0d",
                             o.lane, o.cyc - t0, e.lane, e.cyc - t0);
                end
            end
        end
    endtask

    task automatic test_restart_vs_slip();
        pulse_t e, o;
        relock();
        lw[4] = TRN;
        lw[0] = rotr(TRN, 1);
        rx_locked = 1'b1;
        t0 = cyc;
        run_to(t0 + 68);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_cmp++;
        if (bitslip !== 5'h00 || slip_cnt !== 20'h0 || lane_aligned !== 5'h00) begin
            n_bad++;
            $display("FAIL restart_state: got %b/%h/%b want 00000/00000/00000",
                     bitslip, slip_cnt, lane_aligned);
        end
        exp_q.push_back('{lane: 0, cyc: t0 + 72});
        run_to(t0 + 96);
        n_cmp++;
        if (lane_aligned[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_early: got %b want 0", lane_aligned[0]);
        end
        tick();
        n_cmp++;
        if (all_aligned !== 1'b1 || slip_cnt !== 20'h00001) begin
            n_bad++;
            $display("FAIL restart_done: got %b/%h want 1/00001",
                     all_aligned, slip_cnt);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL restart_count: got %0d extra, want %0d more",
                         obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.lane !== e.lane || o.cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL restart_pulse: got lane %0d cyc %0d want lane %0d cyc %0d",
                             o.lane, o.cyc - t0, e.lane, e.cyc - t0);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        pulse_t e, o;
        relock();
        lw[1] = rotr(TRN, 2);
        rx_locked = 1'b1;
        t0 = cyc;
        exp_q.push_back('{lane: 1, cyc: t0 + 69});
        run_to(t0 + 69);
        n_cmp++;
        if (bitslip !== 5'h02) begin
            n_bad++;
            $display("FAIL arst_pulse_on: got %b want 00010", bitslip);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bitslip, lane_aligned, lane_fail, all_aligned, slip_cnt} !== 36'h0) begin
            n_bad++;
            $display("FAIL arst_clear: got %h want 0",
                     {bitslip, lane_aligned, lane_fail, all_aligned, slip_cnt});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        t0 = cyc;
        exp_q.push_back('{lane: 1, cyc: t0 + 69});
        run_to(t0 + 93);
        n_cmp++;
        if (all_aligned !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_early: got %b want 0", all_aligned);
        end
        tick();
        n_cmp++;
        if (all_aligned !== 1'b1 || slip_cnt !== 20'h00010) begin
            n_bad++;
            $display("FAIL arst_done: got %b/%h want 1/00010",
                     all_aligned, slip_cnt);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL arst_count: got %0d extra, want %0d more",
                         obs_q.size(), exp_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.lane !== e.lane || o.cyc !== e.cyc) begin
                    n_bad++;
                    $display("FAIL arst_pulse: got lane %0d cyc %0d want lane %0d cyc %0d",
                             o.lane, o.cyc, e.lane, e.cyc);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_locked = 1'b0;
        restart   = 1'b0;
        cyc       = 0;
        t0        = 0;
        n_cmp     = 0;
        n_bad     = 0;
        for (int i = 0; i < 5; i++) lw[i] = TRN;
        test_reset();
        test_already_aligned();
        test_lock_loss();
        test_three_slips();
        test_unalignable();
        test_restart_vs_slip();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
